mem_byte_sequencer: RTL

Multi-cycle load/store controller placed between the multicycle RV32I core's memory stage and the byte-organised data memory. It accepts one load or store request at a time, checks alignment, range and width, and sequences 1, 2 or 4 byte-wide accesses to the memory. For loads it assembles the result with sign or zero extension, then returns a response through a valid/ready handshake. This is the only block that drives the data memory's write-enable.

---
 rtl/mem_byte_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_byte_sequencer.sv
// Byte-serial load/store sequencer between the core memory stage and a byte-wide data memory.
// Checks each request, walks 1/2/4 byte accesses, extends loads and returns a valid/ready response.
module mem_byte_sequencer #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_wd,
  input  logic [7:0]  mem_rd
);

  // state    | meaning
  // IDLE     | waiting for a request, req_ready high
  // ACCESS   | one memory byte per cycle at r_addr + r_idx
  // RESP     | response held until resp_ready
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_addr;
  logic [1:0]  r_idx;
  logic [1:0]  r_last;
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_rbuf;
  logic [31:0] r_resp_rdata;
  logic        r_resp_err;

  logic [32:0] w_nbytes;
  logic [1:0]  w_last_idx;
  logic        w_f3_legal;
  logic        w_misalign;
  logic        w_oob;
  logic        w_err;
  logic [31:0] w_buf_next;
  logic [31:0] w_ext;

  always_comb begin
    w_nbytes   = 33'd4;
    w_last_idx = 2'd3;
    case (req_funct3[1:0])
      2'b00: begin w_nbytes = 33'd1; w_last_idx = 2'd0; end
      2'b01: begin w_nbytes = 33'd2; w_last_idx = 2'd1; end
      default: ;
    endcase
  end

  always_comb begin
    w_f3_legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_f3_legal = 1'b1;
      3'b100, 3'b101:         w_f3_legal = ~req_store;
      default:                w_f3_legal = 1'b0;
    endcase
  end

  // Range end computed in 33 bits so addresses near 2^32 cannot wrap into range.
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign w_oob      = ({1'b0, req_addr} + w_nbytes) > 33'(MEM_BYTES);
  assign w_err      = ~w_f3_legal | w_misalign | w_oob;

  always_comb begin
    w_buf_next = r_rbuf;
    w_buf_next[{r_idx, 3'b000} +: 8] = mem_rd;
  end

  always_comb begin
    case (r_funct3)
      3'b000:  w_ext = {{24{w_buf_next[7]}}, w_buf_next[7:0]};
      3'b001:  w_ext = {{16{w_buf_next[15]}}, w_buf_next[15:0]};
      3'b100:  w_ext = {24'd0, w_buf_next[7:0]};
      3'b101:  w_ext = {16'd0, w_buf_next[15:0]};
      default: w_ext = w_buf_next;
    endcase
  end

  // r_idx stops at the last byte so mem_a/mem_wd hold their final values after ACCESS.
  assign mem_a      = r_addr + {30'd0, r_idx};
  assign mem_wd     = r_wdata[{r_idx, 3'b000} +: 8];
  assign mem_we     = (r_state == S_ACCESS) && r_store;
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_addr       <= 32'd0;
      r_idx        <= 2'd0;
      r_last       <= 2'd0;
      r_store      <= 1'b0;
      r_funct3     <= 3'd0;
      r_wdata      <= 32'd0;
      r_rbuf       <= 32'd0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            if (w_err) begin
              r_resp_err   <= 1'b1;
              r_resp_rdata <= 32'd0;
              r_state      <= S_RESP;
            end else begin
              r_addr     <= req_addr;
              r_store    <= req_store;
              r_funct3   <= req_funct3;
              r_wdata    <= req_wdata;
              r_idx      <= 2'd0;
              r_last     <= w_last_idx;
              r_rbuf     <= 32'd0;
              r_resp_err <= 1'b0;
              r_state    <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!r_store) r_rbuf <= w_buf_next;
          if (r_idx == r_last) begin
            r_resp_rdata <= r_store ? 32'd0 : w_ext;
            r_state      <= S_RESP;
          end else begin
            r_idx <= r_idx + 2'd1;
          end
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
